// File: rtl/wb_pkg.sv
// Shared widths, register-file geometry and index/data types for the writeback stage.
package wb_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 2 ** ADDR_W;
    localparam int R0_IDX = 0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/wb_dec_onehot.sv
// Address to one-hot write-enable decoder; all-zero when disabled, optionally never selects R0.
module wb_dec_onehot
    import wb_pkg::*;
#(
    parameter int ADDR_W  = wb_pkg::ADDR_W,
    parameter int ZERO_R0 = 1
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
        if (ZERO_R0 != 0) onehot[R0_IDX] = 1'b0;
    end
endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback pending register plus 16-entry register file with two combinational read ports.
// Optional forwarding of the pending write onto the read ports: define WB_BYPASS_EN.
module wb_regfile_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = wb_pkg::DATA_W,
    parameter int ADDR_W  = wb_pkg::ADDR_W,
    parameter int ZERO_R0 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 stall,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic [DATA_W-1:0]    rd_data_a,
    output logic [DATA_W-1:0]    rd_data_b,
    output logic                 hazard_a,
    output logic                 hazard_b,
    output logic [2**ADDR_W-1:0] wr_en_onehot,
    output logic                 pend_valid
);
    localparam int N_REG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [N_REG];
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] raw_a;
    logic [DATA_W-1:0] raw_b;

    function automatic logic r0_excl(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    wb_dec_onehot #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_dec (
        .en     (pend_valid & ~stall),
        .addr   (pend_addr),
        .onehot (wr_en_onehot)
    );

    // Reset wins over a commit, so a write pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REG; i++) regs[i] <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                if (wr_en_onehot[i]) regs[i] <= pend_data;
            end
            if (!stall) begin
                pend_valid <= wb_valid;
                if (wb_valid) begin
                    pend_addr <= wb_addr;
                    pend_data <= wb_data;
                end
            end
        end
    end

    always_comb begin
        raw_a = r0_excl(rd_addr_a) ? '0 : regs[rd_addr_a];
        raw_b = r0_excl(rd_addr_b) ? '0 : regs[rd_addr_b];
        hit_a = pend_valid && (pend_addr == rd_addr_a) && !r0_excl(rd_addr_a);
        hit_b = pend_valid && (pend_addr == rd_addr_b) && !r0_excl(rd_addr_b);
    end

`ifdef WB_BYPASS_EN
    assign rd_data_a = hit_a ? pend_data : raw_a;
    assign rd_data_b = hit_b ? pend_data : raw_b;
    assign hazard_a  = 1'b0;
    assign hazard_b  = 1'b0;
`else
    assign rd_data_a = raw_a;
    assign rd_data_b = raw_b;
    assign hazard_a  = hit_a;
    assign hazard_b  = hit_b;
`endif
endmodule
